gpioemu_mulpop: RTL and testbench

- Parametrised successor of the bus-mapped GPIO emulator arithmetic peripheral.
- Software writes two unsigned operands, then starts an operation.
- The block runs a sequential shift-add multiply, then a bit-serial popcount of the low result word.
- Results, status and a completion counter are exposed over the same srd/swr register bus and on gpio_out.

---
 rtl/gpioemu_mulpop.sv | 197 +++++++++++++++++++
 tb/tb_gpioemu_mulpop.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped shift-add multiplier with bit-serial popcount and completion counter.
// Optional overflow counter at +0x28 is built when GPIOEMU_MULPOP_ERRCNT_EN is defined.
module gpioemu_mulpop #(
  parameter int unsigned OPW       = 24,
  parameter int unsigned RESW      = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int unsigned CNTW      = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int unsigned PW = 2 * OPW;
  localparam int unsigned XW = (PW > RESW) ? PW : RESW;
  localparam int unsigned LW = $clog2(RESW + 1);
  localparam int unsigned MW = (OPW > RESW) ? OPW : RESW;
  localparam int unsigned SW = $clog2(MW + 1);

  typedef enum logic [1:0] {StIdle, StMult, StCount, StDone} state_e;

  state_e            state_q, state_d;
  logic [OPW-1:0]    a1_q, a2_q;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [OPW-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [LW-1:0]     pop_q, pop_d;
  logic [SW-1:0]     step_q, step_d;
  logic [RESW-1:0]   w_q;
  logic [LW-1:0]     l_q;
  logic              valid_q, ready_q;
  logic [CNTW-1:0]   cnt_q;
  logic [31:0]       gpio_in_s_q;
  logic [31:0]       rdata_q, rdata_d;

  logic sel_a1, sel_a2, sel_w, sel_l, sel_ctrl;
  logic start, op_zero, done;
  logic [XW-1:0]   prod_ext;
  logic [XW-1:0]   prod_shift;
  logic [RESW-1:0] res_w;
  logic            res_hi_zero;
  logic            unused_sdata;

  assign sel_a1   = (saddress == BASE_ADDR);
  assign sel_a2   = (saddress == BASE_ADDR + 16'h0008);
  assign sel_w    = (saddress == BASE_ADDR + 16'h0010);
  assign sel_l    = (saddress == BASE_ADDR + 16'h0018);
  assign sel_ctrl = (saddress == BASE_ADDR + 16'h0020);

  assign start   = swr && sel_ctrl && ready_q;
  assign op_zero = (a1_q == '0) || (a2_q == '0);
  assign done    = (state_q == StDone);

  // Product widened so both the result slice and the overflow test stay legal for any widths.
  assign prod_ext    = XW'(acc_q);
  assign prod_shift  = prod_ext >> step_q;
  assign res_w       = prod_ext[RESW-1:0];
  assign res_hi_zero = ((prod_ext >> RESW) == '0);

  assign unused_sdata = ^sdata_in;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      pop_q    <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      pop_q    <= pop_d;
      step_q   <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    pop_d    = pop_q;
    step_d   = step_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = PW'(a1_q);
          mplier_d = a2_q;
          acc_d    = '0;
          pop_d    = '0;
          step_d   = '0;
          state_d  = op_zero ? StDone : StMult;
        end
      end
      StMult: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (step_q == SW'(OPW - 1)) begin
          step_d  = '0;
          state_d = StCount;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      StCount: begin
        pop_d = pop_q + LW'(prod_shift[0]);
        if (step_q == SW'(RESW - 1)) begin
          step_d  = '0;
          state_d = StDone;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef GPIOEMU_MULPOP_ERRCNT_EN
  logic        sel_err;
  logic [15:0] errcnt_q;

  assign sel_err = (saddress == BASE_ADDR + 16'h0028);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      errcnt_q <= '0;
    end else if (done && !res_hi_zero && (errcnt_q != 16'hFFFF)) begin
      errcnt_q <= errcnt_q + 16'd1;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (sel_a1) begin
      rdata_d = 32'(a1_q);
    end else if (sel_a2) begin
      rdata_d = 32'(a2_q);
    end else if (sel_w) begin
      rdata_d = 32'(w_q);
    end else if (sel_l) begin
      rdata_d = 32'(l_q);
    end else if (sel_ctrl) begin
      rdata_d = {30'b0, ready_q, valid_q};
`ifdef GPIOEMU_MULPOP_ERRCNT_EN
    end else if (sel_err) begin
      rdata_d = {16'b0, errcnt_q};
`endif
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is not visible to the read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q        <= '0;
      a2_q        <= '0;
      w_q         <= '0;
      l_q         <= '0;
      valid_q     <= 1'b1;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      gpio_in_s_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (swr && sel_a1) a1_q <= sdata_in[OPW-1:0];
      if (swr && sel_a2) a2_q <= sdata_in[OPW-1:0];
      if (start) ready_q <= 1'b0;
      if (done) begin
        w_q     <= res_w;
        l_q     <= pop_q;
        valid_q <= res_hi_zero;
        ready_q <= 1'b1;
        cnt_q   <= cnt_q + CNTW'(1);
      end
      if (gpio_latch) gpio_in_s_q <= gpio_in;
      if (srd) rdata_q <= rdata_d;
    end
  end

  assign sdata_out      = rdata_q;
  assign gpio_out       = 32'(cnt_q);
  assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Randomized self-checking bench for gpioemu_mulpop against an arithmetic reference model;
// a second instance with CNTW=4 shares the bus to exercise counter wrap.
module tb_gpioemu_mulpop;

  localparam logic [15:0] Base = 16'h0380;
  localparam logic [7:0]  OffA1 = 8'h00, OffA2 = 8'h08, OffW = 8'h10, OffL = 8'h18;
  localparam logic [7:0]  OffCtrl = 8'h20, OffErr = 8'h28, OffUnm = 8'h30;
  localparam int unsigned Lat = 24 + 32 + 1;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out, sdata_out4;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_out, gpio_out4;
  logic [31:0] gpio_in_s_insp, gpio_in_s_insp4;

  gpioemu_mulpop u_dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  gpioemu_mulpop #(.CNTW(4)) u_dut4 (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out4),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out4),
    .gpio_in_s_insp (gpio_in_s_insp4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: last published result and counters.
  int unsigned m_cnt;
  logic [31:0] m_w;
  int unsigned m_l;
  logic        m_valid;
  int unsigned m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
    saddress = Base + 16'(off);
    sdata_in = d;
    swr      = 1'b1;
    @(posedge clk); #1;
    swr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [31:0] d);
    saddress = Base + 16'(off);
    srd      = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    d   = sdata_out;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(off, d);
    check(tag, d, exp);
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_w     = '0;
    m_l     = 0;
    m_valid = 1'b1;
    m_err   = 0;
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b, output int unsigned k);
    bus_wr(OffA1, 32'(a));
    bus_wr(OffA2, 32'(b));
    bus_wr(OffCtrl, 32'h1);
    k = cyc;
  endtask

  task automatic finish_op(input logic [23:0] a, input logic [23:0] b, input int unsigned k);
    longint unsigned p;
    logic [31:0]     ew;
    logic            ev;
    int unsigned     lat;
    int unsigned     elat;
    logic [31:0]     old;
    old = 32'(m_cnt);
    while (gpio_out == old && (cyc - k) < 300) begin
      @(posedge clk); #1;
    end
    if (gpio_out == old) check("done_timeout", gpio_out, old + 1);
    lat  = cyc - k;
    p    = longint'(a) * longint'(b);
    ew   = p[31:0];
    ev   = ((p >> 32) == 0);
    elat = (a == 0 || b == 0) ? 1 : Lat;
    check("latency", lat, elat);
    m_cnt++;
    check("gpio_out", gpio_out, 32'(m_cnt));
    check("gpio_out_cnt4", gpio_out4, 32'(m_cnt % 16));
    rd_check("w", OffW, ew);
    rd_check("l", OffL, 32'($countones(ew)));
    rd_check("status_done", OffCtrl, {30'b0, 1'b1, ev});
    m_w     = ew;
    m_l     = $countones(ew);
    m_valid = ev;
    if (!ev) m_err++;
  endtask

  task automatic run_op(input logic [23:0] a, input logic [23:0] b);
    int unsigned k;
    start_op(a, b, k);
    rd_check("status_busy", OffCtrl, {30'b0, 1'b0, m_valid});
    if (a != 0 && b != 0) rd_check("w_busy", OffW, m_w);
    finish_op(a, b, k);
  endtask

  function automatic logic [23:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 24'h0;
      1:       return 24'($urandom_range(1, 255));
      2:       return 24'($urandom);
      default: return 24'hFFFFFF - 24'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int unsigned k;
    logic [23:0] a0, b0;
    logic [31:0] g;

    n_reset    = 1'b0;
    saddress   = '0;
    srd        = 1'b0;
    swr        = 1'b0;
    sdata_in   = '0;
    gpio_in    = '0;
    gpio_latch = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;

    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_insp", gpio_in_s_insp, 32'h0);
    rd_check("rst_a1", OffA1, 32'h0);
    rd_check("rst_a2", OffA2, 32'h0);
    rd_check("rst_w", OffW, 32'h0);
    rd_check("rst_l", OffL, 32'h0);
    rd_check("rst_status", OffCtrl, 32'h3);

    run_op(24'd3, 24'd5);
    run_op(24'd0, 24'd7);
    run_op(24'hFFFFFF, 24'hFFFFFF);
`ifdef GPIOEMU_MULPOP_ERRCNT_EN
    rd_check("errcnt", OffErr, 32'(m_err));
`else
    rd_check("errcnt_unmapped", OffErr, 32'h0);
`endif

    // Second start mid-operation is ignored; the running op keeps its snapshot.
    a0 = 24'h000123;
    b0 = 24'h000045;
    start_op(a0, b0, k);
    while (cyc < k + 9) begin
      @(posedge clk); #1;
    end
    bus_wr(OffA1, 32'd9);
    bus_wr(OffCtrl, 32'h1);
    finish_op(a0, b0, k);
    repeat (70) @(posedge clk);
    #1 check("no_second_start", gpio_out, 32'(m_cnt));
    rd_check("a1_written", OffA1, 32'd9);
    bus_wr(OffCtrl, 32'h1);
    k = cyc;
    finish_op(24'd9, b0, k);

    // Bus corner cases.
    g = 32'($urandom);
    gpio_in = g;
    @(posedge clk); #1;
    check("insp_no_latch", gpio_in_s_insp, 32'h0);
    gpio_latch = 1'b1;
    @(posedge clk); #1;
    gpio_latch = 1'b0;
    gpio_in    = ~g;
    check("insp_latched", gpio_in_s_insp, g);
    saddress = Base + 16'(OffA1);
    sdata_in = 32'hFF5A5A5A;
    srd      = 1'b1;
    swr      = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    swr = 1'b0;
    check("rdwr_pre_value", sdata_out, 32'd9);
    rd_check("a1_truncated", OffA1, 32'h005A5A5A);
    bus_wr(OffW, 32'hDEADBEEF);
    rd_check("w_read_only", OffW, m_w);
    bus_wr(OffUnm, 32'hDEADBEEF);
    rd_check("unmapped", OffUnm, 32'h0);

    // Asynchronous reset in the middle of a multiply.
    start_op(24'h00ABCD, 24'h000321, k);
    while (cyc < k + 20) begin
      @(posedge clk); #1;
    end
    n_reset = 1'b0;
    #1;
    model_reset();
    check("abort_gpio_out", gpio_out, 32'h0);
    check("abort_gpio_out4", gpio_out4, 32'h0);
    check("abort_sdata_out", sdata_out, 32'h0);
    check("abort_insp", gpio_in_s_insp, 32'h0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    rd_check("abort_a1", OffA1, 32'h0);
    rd_check("abort_w", OffW, 32'h0);
    rd_check("abort_status", OffCtrl, 32'h3);
    run_op(24'd2, 24'd3);
    check("w_2x3", m_w, 32'd6);

    for (int i = 0; i < 16; i++) run_op(24'd0, 24'($urandom_range(1, 1000)));

    for (int i = 0; i < 30; i++) run_op(rand_opnd(), rand_opnd());
`ifdef GPIOEMU_MULPOP_ERRCNT_EN
    rd_check("errcnt_final", OffErr, 32'(m_err));
`else
    rd_check("errcnt_final_unmapped", OffErr, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
